// File: rtl/demux_rr_scheduler.sv
// Round-robin scheduler that drives the select/data pair of a 1:4 demux.
// Each grant is a fixed-length high window on i, followed by a one-cycle ack and an idle cycle.
module demux_rr_scheduler #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic       i,
  output logic [3:0] ack,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  // DWELL of 0 behaves like 1: the window always lasts at least one cycle.
  localparam int LOAD_INT = (DWELL <= 1) ? 0 : DWELL - 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = LOAD_INT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_reg, state_next;
  logic [1:0]       sel_reg, sel_next;
  logic [1:0]       last_reg, last_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             i_reg, i_next;
  logic [3:0]       ack_reg, ack_next;

  logic [1:0] cand [4];
  logic [3:0] hit;
  logic       grant_valid;
  logic [1:0] grant_ch;

  // cand[gi] is the channel at search position gi, starting just after last.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
      assign cand[gi] = last_reg + 2'(gi + 1);
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  always_comb begin
    grant_valid = |hit;
    grant_ch    = cand[0];
    for (int k = 3; k >= 0; k--) begin
      if (hit[k]) grant_ch = cand[k];
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    i_next     = 1'b0;
    ack_next   = 4'b0000;
    case (state_reg)
      IDLE: begin
        if (en && grant_valid) begin
          sel_next   = grant_ch;
          last_next  = grant_ch;
          cnt_next   = CNT_LOAD;
          state_next = ACTIVE;
          i_next     = 1'b1;
        end
      end
      ACTIVE: begin
        if (cnt_reg == '0) begin
          state_next = GAP;
          ack_next   = 4'b0001 << sel_reg;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
          i_next   = 1'b1;
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sel_reg   <= 2'd0;
      last_reg  <= 2'd3;
      cnt_reg   <= '0;
      i_reg     <= 1'b0;
      ack_reg   <= 4'b0000;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
      i_reg     <= i_next;
      ack_reg   <= ack_next;
    end
  end

  assign sel  = sel_reg;
  assign i    = i_reg;
  assign ack  = ack_reg;
  assign busy = (state_reg != IDLE);

endmodule
